// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction fetch stage that sits directly upstream of the text memory bus.
// It drives the fetch address, captures the bus's combinational read data into
// a small FIFO together with the PC of each word, and presents the oldest
// entry to the decode/core stage.
//
// Parameters:
//   DEPTH     number of queue entries (legal range 2..8)
//   RESET_PC  first fetch PC after reset (start of the text segment)
//
// Ports:
//   clock          single clock, all state changes on the rising edge
//   reset          synchronous, active-low
//   bus_address    fetch address to the text memory bus (always fetch_pc)
//   bus_read_data  word returned combinationally by the bus for bus_address
//   inst_valid     head entry valid
//   inst_ready     consumer accepts the head entry this cycle
//   inst           head instruction word (0 while the queue is empty)
//   inst_pc        PC of the head instruction (0 while the queue is empty)
//   redirect       flush the queue and restart fetch at redirect_pc
//   redirect_pc    new fetch PC; bits [1:0] are ignored
//   inst_fault     (FETCH_BOUNDS_CHECK_EN only) head entry was fetched
//                  outside the text segment
//
// Handshake: an entry transfers to the consumer on every rising edge where
// inst_valid and inst_ready are both high and redirect is low. inst_valid
// never drops and inst/inst_pc never change while inst_valid=1 and
// inst_ready=0. inst_valid and inst/inst_pc are driven from queue state only,
// so there is no combinational path from inst_ready or bus_read_data to them.
//
// Optional build macro FETCH_BOUNDS_CHECK_EN: adds the inst_fault output and a
// text-segment range check on every fetch. An out-of-range fetch stores a NOP
// instead of the bus data and stops further fetching until a redirect.

`timescale 1ns/1ps

module fetch_prefetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        inst_fault
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] TEXT_BEGIN = RESET_PC;
  localparam logic [31:0] TEXT_END   = 32'h0FFF_FFFC;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
`endif

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      word_mem [DEPTH];

  logic             pop;
  logic             push;
  logic [31:0]      wr_word;

  // Only the word-aligned part of the redirect target is used.
  logic [1:0]       unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];

`ifdef FETCH_BOUNDS_CHECK_EN
  logic             fault_mem [DEPTH];
  logic             fault_stall;
  logic             push_fault;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop decisions. A full queue still accepts a push when the head is
  // leaving in the same cycle: the slot being written is the one being freed.
  always_comb begin
    pop  = inst_valid & inst_ready & ~redirect;
`ifdef FETCH_BOUNDS_CHECK_EN
    push_fault = (fetch_pc < TEXT_BEGIN) | (fetch_pc > TEXT_END);
    push       = ~redirect & ~fault_stall & ((count < CNT_DEPTH) | pop);
    wr_word    = push_fault ? NOP_WORD : bus_read_data;
`else
    push    = ~redirect & ((count < CNT_DEPTH) | pop);
    wr_word = bus_read_data;
`endif
  end

  // Control state: fetch PC, pointers, occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Once a faulting word is queued nothing sensible follows it; hold fetch
  // until the core redirects (typically into a trap handler).
  always_ff @(posedge clock) begin
    if (!reset || redirect) begin
      fault_stall <= 1'b0;
    end else if (push && push_fault) begin
      fault_stall <= 1'b1;
    end
  end
`endif

  // Entry storage needs no reset: entries are only observable while counted.
  // push is already suppressed during a redirect.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      word_mem[wr_ptr]  <= wr_word;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_mem[wr_ptr] <= push_fault;
`endif
    end
  end

  // Outputs come straight from queue state.
  always_comb begin
    bus_address = fetch_pc;
    inst_valid  = (count != '0);
    inst        = inst_valid ? word_mem[rd_ptr] : 32'h0;
    inst_pc     = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
`ifdef FETCH_BOUNDS_CHECK_EN
    inst_fault  = inst_valid & fault_mem[rd_ptr];
`endif
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction fetch stage directly upstream of example_text_memory_bus: drives its address input and captures its combinational read_data.
- Holds fetched words with their PCs in a small FIFO and hands them to the decode/core stage over a valid/ready handshake.
- Supports a single-cycle redirect (branch/jump/trap) that flushes all queued words and restarts fetch at a new PC.

Parameters:
- DEPTH, 2, number of queue entries; legal values 2..8.
- RESET_PC, 32'h00400000, first fetch PC after reset (TEXT_BEGIN).

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; state resets on a rising edge while reset==0
- bus_address  output  32  fetch address to text memory bus; always equals fetch_pc
- bus_read_data  input  32  word returned combinationally by text memory bus for bus_address
- inst_valid  output  1  head entry valid
- inst_ready  input  1  consumer accepts head this cycle
- inst  output  32  head instruction word
- inst_pc  output  32  PC of head instruction
- redirect  input  1  flush queue and restart fetch
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced to 0)

Behaviour:
- State: fetch_pc[31:0], entry arrays pc/word[DEPTH], rd_ptr, wr_ptr (mod DEPTH), count (0..DEPTH).
- Reset (reset==0 at edge): fetch_pc=RESET_PC, count=0, pointers=0. inst_valid=0; inst and inst_pc read 0 while count==0.
- pop = inst_valid & inst_ready & ~redirect.
- push = ~redirect & (count<DEPTH | pop). Full queue with a same-cycle pop still pushes.
- On push: entry[wr_ptr] = {fetch_pc, bus_read_data}; wr_ptr++; fetch_pc = fetch_pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
- On pop: rd_ptr++. count updates by push-pop; a simultaneous push and pop leaves count unchanged.
- Outputs are registered: inst_valid = (count!=0); inst/inst_pc come from entry[rd_ptr]. No combinational path from bus_read_data or inst_ready to inst/inst_valid.
- Latency: a word fetched in cycle N is visible at the head in cycle N+1 if the queue was empty. Sustained throughput is 1 instr/cycle with inst_ready held high.
- Redirect, highest priority: count=0, pointers=0, fetch_pc={redirect_pc[31:2],2'b00}. No push and no pop in that cycle. inst_valid=0 in the next cycle. The first post-redirect word is at the head 2 cycles after the redirect cycle.
- Redirect asserted on consecutive cycles: the last redirect_pc wins.
- Reset overrides redirect.
- Reset mid-stream discards all entries.
- Full (count==DEPTH) with inst_ready=0: fetch_pc holds, and bus_address is stable at the next unfetched PC.
- Consumer contract: inst/inst_pc are stable while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- With the macro:
  - Adds output port inst_fault (1 bit) and a fault bit per entry.
  - fault = (fetch_pc < TEXT_BEGIN) | (fetch_pc > TEXT_END) at push.
  - A faulting entry stores word 32'h00000013 (NOP) instead of bus_read_data, so no X is propagated.
  - inst_fault mirrors the head entry's fault bit; reset value 0.
  - After pushing a faulting entry, push stalls until a redirect arrives. The queue drains normally.
- Without the macro: no inst_fault port, no range check, and bus_read_data is stored unmodified.

Test Plan:
- Reset then inst_ready=1 constant, memory word=PC^32'hA5A5A5A5 -> inst_valid first high 1 cycle after reset release with inst_pc=0x00400000; next cycles give pcs 0x00400004, 0x00400008, one per cycle.
- inst_ready=0 for 5 cycles after reset -> count saturates at DEPTH=2; bus_address holds 0x00400008; releasing inst_ready delivers 0x00400000, 0x00400004, 0x00400008 with no gap or duplicate.
- Redirect to 0x00400103 while the queue is full and inst_ready=1 -> no pop that cycle; inst_valid=0 next cycle; then inst_pc=0x00400100, 0x00400104.
- Redirect on two consecutive cycles (0x00400040, then 0x00400080) -> first delivered inst_pc=0x00400080.
- Reset driven low mid-stream with 2 entries queued -> next cycle inst_valid=0 and bus_address=0x00400000.
- With FETCH_BOUNDS_CHECK_EN: redirect to TEXT_END-4 -> entries TEXT_END-4 (fault 0) and TEXT_END (fault 0), then TEXT_END+4 with inst_fault=1 and inst=0x00000013; fetch stalls until the next redirect.
